// File: rtl/iic_sw_pkg.sv
// Shared types and width helpers for the I2C channel switch.
package iic_sw_pkg;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    CONN      = 2'd1,
    WAIT_IDLE = 2'd2,
    GAP       = 2'd3
  } iic_sw_state_t;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/iic_idle_det.sv
// Counts consecutive bus-idle cycles; idle_ok fires on the cycle that
// completes IDLE_CYC idle samples in a row.
module iic_idle_det
  import iic_sw_pkg::*;
#(
  parameter int IDLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic scl_oe,
  input  logic sda_oe,
  input  logic scl_in,
  input  logic sda_in,
  output logic idle_ok
);

  localparam int IW = cnt_w(IDLE_CYC);
  localparam logic [IW-1:0] CNT_MAX  = IW'(IDLE_CYC);
  localparam logic [IW-1:0] CNT_LAST = IW'(IDLE_CYC - 1);

  logic [IW-1:0] cnt;
  logic          idle_now;

  assign idle_now = ~scl_oe & ~sda_oe & scl_in & sda_in;
  // The current sample counts toward the run, so the switch can start
  // right after the IDLE_CYC-th idle cycle.
  assign idle_ok  = idle_now && (cnt >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || !idle_now) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + IW'(1);
    end
  end

endmodule

// File: rtl/iic_chan_switch.sv
// Steers one upstream I2C master onto one of NCH downstream channels with
// idle-qualified, break-before-make switching and an optional hang timeout.
module iic_chan_switch
  import iic_sw_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int SEL_W    = 8,
  parameter int IDLE_CYC = 16,
  parameter int GAP_CYC  = 4,
  parameter int TMO_CYC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_chan,
  output logic             req_ready,
  input  logic             m_scl_oe,
  input  logic             m_sda_oe,
  output logic             m_scl_in,
  output logic             m_sda_in,
  output logic [NCH-1:0]   ch_scl_oe,
  output logic [NCH-1:0]   ch_sda_oe,
  input  logic [NCH-1:0]   ch_scl_in,
  input  logic [NCH-1:0]   ch_sda_in,
  output logic             cur_valid,
  output logic [SEL_W-1:0] cur_chan,
  output logic             done,
  output logic             err_bad_chan,
  output logic             err_timeout
);

  localparam int GW = cnt_w(GAP_CYC);
  localparam int TW = cnt_w(TMO_CYC);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TMO_CYC);
  localparam logic [TW-1:0]  TMO_LAST = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
  localparam logic [SEL_W:0] NCH_EXT  = (SEL_W + 1)'(NCH);

  iic_sw_state_t    state, state_nxt;
  logic [SEL_W-1:0] target;
  logic [GW-1:0]    gcnt;
  logic [TW-1:0]    tcnt;
  logic [NCH-1:0]   sel_hit;

  logic accept, bad, same, load;
  logic gap_end, tmo_hit, idle_ok, timeout_fire;

  iic_idle_det #(
    .IDLE_CYC(IDLE_CYC)
  ) u_idle (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != WAIT_IDLE),
    .scl_oe (m_scl_oe),
    .sda_oe (m_sda_oe),
    .scl_in (m_scl_in),
    .sda_in (m_sda_in),
    .idle_ok(idle_ok)
  );

  // Connected only while the current channel is live on the bus.
  assign cur_valid = (state == CONN) || (state == WAIT_IDLE);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign sel_hit[i]   = (cur_chan == SEL_W'(i));
    assign ch_scl_oe[i] = cur_valid & sel_hit[i] & m_scl_oe;
    assign ch_sda_oe[i] = cur_valid & sel_hit[i] & m_sda_oe;
  end

  assign m_scl_in = ~cur_valid | (|(ch_scl_in & sel_hit));
  assign m_sda_in = ~cur_valid | (|(ch_sda_in & sel_hit));

  assign gap_end      = (gcnt == GAP_LAST);
  assign tmo_hit      = (TMO_CYC > 0) && (tcnt == TMO_LAST);
  assign timeout_fire = (state == WAIT_IDLE) && tmo_hit && !idle_ok;

  always_comb begin
    state_nxt = state;
    req_ready = (state == NONE) || (state == CONN);
    accept    = req_valid && req_ready;
    bad       = accept && ({1'b0, req_chan} >= NCH_EXT);
    same      = accept && !bad && (state == CONN) && (req_chan == cur_chan);
    load      = accept && !bad && !same;
    case (state)
      NONE:      if (load) state_nxt = GAP;
      CONN:      if (load) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (idle_ok || tmo_hit) state_nxt = GAP;
      GAP:       if (gap_end) state_nxt = CONN;
      default:   state_nxt = NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= NONE;
      cur_chan     <= '0;
      gcnt         <= '0;
      tcnt         <= '0;
      done         <= 1'b0;
      err_bad_chan <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      done         <= same || ((state == GAP) && gap_end);
      err_bad_chan <= bad;
      err_timeout  <= timeout_fire;
      gcnt         <= ((state == GAP) && !gap_end) ? gcnt + GW'(1) : '0;
      if (state != WAIT_IDLE) begin
        tcnt <= '0;
      end else if (tcnt != TMO_MAX) begin
        tcnt <= tcnt + TW'(1);
      end
      if ((state == GAP) && gap_end) begin
        cur_chan <= target;
      end
    end
  end

  // Pending target is plain data; a reset makes it irrelevant via the FSM.
  always_ff @(posedge clk) begin
    if (load) begin
      target <= req_chan;
    end
  end

endmodule

// File: tb/tb_iic_chan_switch.sv
// Directed bench for iic_chan_switch: connect, idle-qualified switch,
// bad/same channel, hang timeout and reset during the gap.
module tb_iic_chan_switch;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_chan;
  logic       req_ready;
  logic       m_scl_oe, m_sda_oe;
  logic       m_scl_in, m_sda_in;
  logic [7:0] ch_scl_oe, ch_sda_oe;
  logic [7:0] ch_scl_in, ch_sda_in;
  logic       cur_valid;
  logic [7:0] cur_chan;
  logic       done, err_bad_chan, err_timeout;
  logic [7:0] scl_stuck, sda_stuck;

  int checks = 0;
  int errors = 0;

  // Pad model: a line is low if the switch or a stuck device pulls it.
  assign ch_scl_in = ~(ch_scl_oe | scl_stuck);
  assign ch_sda_in = ~(ch_sda_oe | sda_stuck);

  iic_chan_switch #(
    .NCH(8), .SEL_W(8), .IDLE_CYC(16), .GAP_CYC(4), .TMO_CYC(100)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_chan(req_chan), .req_ready(req_ready),
    .m_scl_oe(m_scl_oe), .m_sda_oe(m_sda_oe),
    .m_scl_in(m_scl_in), .m_sda_in(m_sda_in),
    .ch_scl_oe(ch_scl_oe), .ch_sda_oe(ch_sda_oe),
    .ch_scl_in(ch_scl_in), .ch_sda_in(ch_sda_in),
    .cur_valid(cur_valid), .cur_chan(cur_chan),
    .done(done), .err_bad_chan(err_bad_chan), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] c);
    req_valid = 1'b1;
    req_chan  = c;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    m_scl_oe = 1'b1; m_sda_oe = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (ch_scl_oe !== 8'h00) begin errors++; $display("FAIL reset_scl_oe: got %h expected 00", ch_scl_oe); end
    checks++; if (ch_sda_oe !== 8'h00) begin errors++; $display("FAIL reset_sda_oe: got %h expected 00", ch_sda_oe); end
    checks++; if (m_scl_in !== 1'b1) begin errors++; $display("FAIL reset_m_scl_in: got %b expected 1", m_scl_in); end
    checks++; if (m_sda_in !== 1'b1) begin errors++; $display("FAIL reset_m_sda_in: got %b expected 1", m_sda_in); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (cur_valid !== 1'b0) begin errors++; $display("FAIL reset_cur_valid: got %b expected 0", cur_valid); end
    checks++; if (cur_chan !== 8'd0) begin errors++; $display("FAIL reset_cur_chan: got %0d expected 0", cur_chan); end
    checks++; if ({done, err_bad_chan, err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {done, err_bad_chan, err_timeout}); end
    m_scl_oe = 1'b0; m_sda_oe = 1'b0;
  endtask

  task automatic test_first_connect;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b expected 1", req_ready); end
    send_req(8'd3);
    for (int k = 1; k <= 4; k++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL first_gap_done c%0d: got %b expected 0", k, done); end
      checks++; if (cur_valid !== 1'b0) begin errors++; $display("FAIL first_gap_valid c%0d: got %b expected 0", k, cur_valid); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL first_gap_ready c%0d: got %b expected 0", k, req_ready); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL first_done: got %b expected 1", done); end
    checks++; if (cur_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", cur_valid); end
    checks++; if (cur_chan !== 8'd3) begin errors++; $display("FAIL first_chan: got %0d expected 3", cur_chan); end
    m_sda_oe = 1'b1;
    #1;
    checks++; if (ch_sda_oe !== 8'b0000_1000) begin errors++; $display("FAIL first_sda_oe: got %b expected 00001000", ch_sda_oe); end
    checks++; if (ch_scl_oe !== 8'h00) begin errors++; $display("FAIL first_scl_oe: got %b expected 00000000", ch_scl_oe); end
    checks++; if (m_sda_in !== 1'b0) begin errors++; $display("FAIL first_sda_ret: got %b expected 0", m_sda_in); end
    checks++; if (m_scl_in !== 1'b1) begin errors++; $display("FAIL first_scl_ret: got %b expected 1", m_scl_in); end
    m_sda_oe = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL first_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_switch_wait;
    m_sda_oe = 1'b1;
    send_req(8'd5);
    for (int k = 1; k <= 40; k++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done c%0d: got %b expected 0", k, done); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d: got %b expected 0", k, req_ready); end
      checks++; if (cur_chan !== 8'd3 || cur_valid !== 1'b1) begin errors++; $display("FAIL hold_conn c%0d: got %0d/%b expected 3/1", k, cur_chan, cur_valid); end
      checks++; if (ch_sda_oe !== 8'h08) begin errors++; $display("FAIL hold_sda_oe c%0d: got %b expected 00001000", k, ch_sda_oe); end
      tick();
    end
    m_sda_oe = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL release_done c%0d: got %b expected 0", k, done); end
      checks++; if (cur_valid !== (k < 16)) begin errors++; $display("FAIL release_valid c%0d: got %b expected %b", k, cur_valid, (k < 16)); end
    end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL switch_done: got %b expected 1", done); end
    checks++; if (cur_chan !== 8'd5) begin errors++; $display("FAIL switch_chan: got %0d expected 5", cur_chan); end
    checks++; if (cur_valid !== 1'b1) begin errors++; $display("FAIL switch_valid: got %b expected 1", cur_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL switch_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_bad_same;
    send_req(8'd9);
    checks++; if (err_bad_chan !== 1'b1) begin errors++; $display("FAIL bad_pulse: got %b expected 1", err_bad_chan); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL bad_done: got %b expected 0", done); end
    checks++; if (cur_chan !== 8'd5 || cur_valid !== 1'b1) begin errors++; $display("FAIL bad_conn: got %0d/%b expected 5/1", cur_chan, cur_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b expected 1", req_ready); end
    tick();
    checks++; if (err_bad_chan !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL bad_after: got %b%b expected 00", err_bad_chan, done); end
    m_scl_oe = 1'b1;
    send_req(8'd5);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL same_done: got %b expected 1", done); end
    checks++; if (ch_scl_oe !== 8'h20) begin errors++; $display("FAIL same_scl_oe: got %b expected 00100000", ch_scl_oe); end
    checks++; if (cur_valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %b expected 1", cur_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL same_done_pulse: got %b expected 0", done); end
    checks++; if (ch_scl_oe !== 8'h20) begin errors++; $display("FAIL same_scl_oe2: got %b expected 00100000", ch_scl_oe); end
    m_scl_oe = 1'b0;
  endtask

  task automatic test_timeout;
    scl_stuck = 8'h20;
    #1;
    checks++; if (m_scl_in !== 1'b0) begin errors++; $display("FAIL tmo_stuck_ret: got %b expected 0", m_scl_in); end
    send_req(8'd1);
    for (int k = 1; k <= 99; k++) begin
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early c%0d: got %b expected 0", k, err_timeout); end
      checks++; if (cur_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL tmo_wait c%0d: got %b/%b expected 1/0", k, cur_valid, req_ready); end
      tick();
    end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_c100: got %b expected 0", err_timeout); end
    tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", err_timeout); end
    checks++; if (cur_valid !== 1'b0) begin errors++; $display("FAIL tmo_gap_valid: got %b expected 0", cur_valid); end
    m_sda_oe = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (err_timeout !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL tmo_gap c%0d: got %b%b expected 00", k, err_timeout, done); end
      checks++; if (ch_sda_oe !== 8'h00) begin errors++; $display("FAIL tmo_gap_oe c%0d: got %b expected 00000000", k, ch_sda_oe); end
    end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done: got %b expected 1", done); end
    checks++; if (cur_chan !== 8'd1) begin errors++; $display("FAIL tmo_chan: got %0d expected 1", cur_chan); end
    checks++; if (ch_sda_oe !== 8'h02) begin errors++; $display("FAIL tmo_new_oe: got %b expected 00000010", ch_sda_oe); end
    checks++; if (m_scl_in !== 1'b1) begin errors++; $display("FAIL tmo_new_scl: got %b expected 1", m_scl_in); end
    m_sda_oe = 1'b0;
    scl_stuck = 8'h00;
  endtask

  task automatic test_reset_mid;
    send_req(8'd1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_same_done: got %b expected 1", done); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_req(8'd6);
    tick();
    checks++; if (cur_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_in_gap: got %b/%b expected 0/0", cur_valid, req_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", req_ready); end
    checks++; if (cur_chan !== 8'd0) begin errors++; $display("FAIL mid_chan: got %0d expected 0", cur_chan); end
    for (int k = 1; k <= 6; k++) begin
      checks++; if (done !== 1'b0 || cur_valid !== 1'b0) begin errors++; $display("FAIL mid_idle c%0d: got %b/%b expected 0/0", k, done, cur_valid); end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    send_req(8'd2);
    for (int k = 1; k <= 4; k++) tick();
    checks++; if (done !== 1'b1 || cur_chan !== 8'd2) begin errors++; $display("FAIL b2b_first: got %b/%0d expected 1/2", done, cur_chan); end
    send_req(8'd7);
    for (int k = 1; k <= 19; k++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_wait c%0d: got %b expected 0", k, done); end
      tick();
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_c20: got %b expected 0", done); end
    tick();
    checks++; if (done !== 1'b1 || cur_chan !== 8'd7) begin errors++; $display("FAIL b2b_second: got %b/%0d expected 1/7", done, cur_chan); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_chan = 8'd0;
    m_scl_oe = 1'b0; m_sda_oe = 1'b0;
    scl_stuck = 8'h00; sda_stuck = 8'h00;
    test_reset();
    test_first_connect();
    test_switch_wait();
    test_bad_same();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
